bitonic_frame_loader: RTL and testbench



---
 rtl/bitonic_frame_loader.sv | 87 ++++++++
 tb/tb_bitonic_frame_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bitonic_frame_loader.sv
// Front end for the 16-element bitonic sorter. It collects a valid/ready byte
// stream into a DEPTH-entry frame and fills short frames with PAD_VALUE. The
// frame is then offered to the sorter and held until the sorter takes it.
module bitonic_frame_loader #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       DEPTH     = 16,
   parameter logic [DATA_W-1:0] PAD_VALUE = 8'hFF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          s_data,
   input  logic                       s_valid,
   input  logic                       s_last,
   output logic                       s_ready,
   output logic [DATA_W-1:0]          frame_out [DEPTH],
   output logic                       frame_valid,
   input  logic                       frame_ready,
   output logic [$clog2(DEPTH):0]     frame_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0]  buf_q [DEPTH];
   logic [DATA_W-1:0]  buf_d [DEPTH];
   logic               frame_valid_q, frame_valid_d;
   logic [CNT_W-1:0]   frame_count_q, frame_count_d;

   assign s_ready     = (state_q == FILL);
   assign frame_out   = buf_q;
   assign frame_valid = frame_valid_q;
   assign frame_count = frame_count_q;

   // Next-state: store accepted beats, pad and close the frame, release on handshake
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      buf_d         = buf_q;
      frame_valid_d = frame_valid_q;
      frame_count_d = frame_count_q;
      if (state_q == FILL) begin
         if (s_valid) begin
            buf_d[wr_ptr_q] = s_data;
            if (s_last || (wr_ptr_q == LAST_PTR)) begin
               // Entries past the closing element are padded on the same edge
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  if (PTR_W'(i) > wr_ptr_q) buf_d[i] = PAD_VALUE;
               end
               frame_count_d = CNT_W'(wr_ptr_q) + CNT_W'(1);
               frame_valid_d = 1'b1;
               state_d       = HOLD;
            end else begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
         end
      end else begin
         if (frame_ready) begin
            frame_valid_d = 1'b0;
            wr_ptr_d      = '0;
            state_d       = FILL;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FILL;
         wr_ptr_q      <= '0;
         buf_q         <= '{default: '0};
         frame_valid_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         buf_q         <= buf_d;
         frame_valid_q <= frame_valid_d;
         frame_count_q <= frame_count_d;
      end
   end

endmodule

// File: tb/tb_bitonic_frame_loader.sv
// Scoreboard bench for bitonic_frame_loader: a frame-level reference model
// pushes expected frames, and a monitor compares every presented frame.
module tb_bitonic_frame_loader;

   localparam int unsigned DEPTH = 16;
   localparam logic [7:0]  PAD   = 8'hFF;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [7:0] frame_out [DEPTH];
   logic       frame_valid;
   logic       frame_ready = 1'b0;
   logic [4:0] frame_count;

   typedef struct {
      logic [7:0] d [DEPTH];
      int         cnt;
   } exp_t;

   exp_t       sb [$];
   logic [7:0] cur [$];
   bit         m_hold = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;

   bitonic_frame_loader #(.DATA_W(8), .DEPTH(DEPTH), .PAD_VALUE(PAD)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .frame_out(frame_out),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   // One clock of stimulus; the model predicts what the following edge does.
   task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic fr);
      exp_t e;
      @(negedge clk);
      s_valid = v; s_data = d; s_last = l; frame_ready = fr;
      check("s_ready", 32'(s_ready), 32'(!m_hold));
      if (!m_hold) begin
         if (v) begin
            cur.push_back(d);
            if (l || cur.size() == DEPTH) begin
               for (int i = 0; i < DEPTH; i++) e.d[i] = (i < cur.size()) ? cur[i] : PAD;
               e.cnt = cur.size();
               sb.push_back(e);
               cur.delete();
               m_hold = 1'b1;
            end
         end
      end else if (fr) begin
         m_hold = 1'b0;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 4 && m_hold; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic check_reset_values(input string tag);
      logic all_zero;
      all_zero = 1'b1;
      for (int i = 0; i < DEPTH; i++) if (frame_out[i] !== 8'h00) all_zero = 1'b0;
      check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
      check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
      check({tag, "_frame_out_zero"}, 32'(all_zero), 32'd1);
      check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
   endtask

   // Monitor: compares the presented frame with the scoreboard head every
   // cycle it is valid, and retires it when the handshake completes.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && frame_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_frame", 32'(frame_valid), 32'd0);
            end else begin
               int bad;
               bad = -1;
               for (int i = 0; i < DEPTH; i++)
                  if (bad < 0 && frame_out[i] !== sb[0].d[i]) bad = i;
               if (bad >= 0) check($sformatf("frame_out[%0d]", bad), 32'(frame_out[bad]), 32'(sb[0].d[bad]));
               else check("frame_out", 32'd0, 32'd0 + 32'(bad < 0 ? 0 : 1));
               check("frame_count", 32'(frame_count), 32'(sb[0].cnt));
               if (frame_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      // Reset state
      #2;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Full frame 15..0, then backpressure for 10 cycles
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(15 - i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      check("bp_frame_valid", 32'(frame_valid), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check("release_frame_valid", 32'(frame_valid), 32'd0);

      // Short frame with padding
      for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i * 16), i == 5, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      drain();

      // Streaming: valid and ready tied high, bubbles drop beats
      for (int i = 0; i < 48; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
      drain();

      // Reset mid-fill discards the partial frame
      for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
      @(negedge clk);
      s_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 check_reset_values("midfill_reset");
      cur.delete();
      m_hold = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      drain();

      // Sparse beats, stray s_last while idle, s_last on the 16th element
      for (int k = 0; k < 32; k++) begin
         if (k % 2 == 0) cyc(1'b1, 8'(8'h80 + k / 2), k == 30, 1'b0);
         else            cyc(1'b0, 8'h33, 1'b1, 1'b0);
      end
      drain();

      // Randomised traffic
      for (int i = 0; i < 2000; i++)
         cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 2) != 0));
      drain();
      drain();

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
